hit_judge: RTL and testbench
============================

# hit_judge

Player-input front end for the countdown game: conditions five raw push-buttons (start plus four lanes), lights a pseudo-random target lamp, and judges each press. It drives the `start` level and single-cycle `miss` pulses consumed by the countdown timer/display block, and stops on that block's `fail`. Clock domain is the board 50 MHz clock.

## Interface
- `DEBOUNCE_CYCLES`, default 500_000: stable cycles required before a button level is accepted (10 ms).
- `WINDOW_CYCLES`, default 25_000_000: time allowed to press the lit lane (0.5 s).
- `GAP_CYCLES`, default 5_000_000: lamps-off gap between targets (0.1 s).
- `clock`, input, 1: system clock. Single clock domain.
- `reset`, input, 1: synchronous, active-high reset.
- `btn_start`, input, 1: raw asynchronous start button.
- `btn_lane`, input, 4: raw asynchronous lane buttons.
- `fail`, input, 1: level from the timer; high means time expired.
- `start`, output, 1: level; high while a game is running.
- `miss`, output, 1: one-cycle penalty pulse.
- `lamp`, output, 4: one-hot target lamp; all zero when no target.
- `hit_count`, output, 8: correct presses, saturating at 255.
- `miss_count`, output, 8: misses, saturating at 255.

## Operation
- Each button passes through a 2-flop synchronizer and a debouncer, then a rising-edge detector that gives a one-cycle `press`.
- The debounced level copies the synced level only after the two have differed for `DEBOUNCE_CYCLES` consecutive cycles. Any agreement clears the count.
- The 8-bit LFSR is Fibonacci with taps 8,6,5,4, seed 8'hA5 at reset, and advances every cycle. The target is `lfsr[1:0]`, sampled on ARM->WAIT. Repeating the previous target is legal.
- States: IDLE, ARM, WAIT, DONE.
  - IDLE: `start`=0, `lamp`=0. `start` press -> ARM with counters cleared. Lane presses are ignored.
  - ARM: `start`=1, `lamp`=0, gap counter runs.
    - At `GAP_CYCLES-1` -> WAIT.
    - Any lane press -> miss (early press) and the gap counter restarts.
  - WAIT: `lamp` is the one-hot target and the window counter runs.
    - Exactly one lane pressed and it is the target -> hit, go to ARM.
    - Wrong lane, or more than one lane in the same cycle (including target plus another) -> miss, go to ARM.
    - Window counter reaches `WINDOW_CYCLES-1` with no press -> miss (timeout), go to ARM.
  - DONE: `start`=0, `lamp`=0, no misses. Held until `reset`. `start` presses are ignored.
- `fail`=1 in any state except IDLE -> DONE on the next edge. `fail` has priority over a same-cycle hit or miss, so no pulse is produced and no count changes.
- A `start` press while in ARM or WAIT is ignored.
- Counters saturate and never wrap.

## Timing
- Reset values: `start`=0, `miss`=0, `lamp`=0, `hit_count`=0, `miss_count`=0, state IDLE, LFSR 8'hA5, all debouncers at level 0 with count 0.
- Raw edge at cycle t, held stable:
  - Synced level changes at t+2.
  - Debounced level changes at t+2+`DEBOUNCE_CYCLES`.
  - `press` is high for exactly cycle t+3+`DEBOUNCE_CYCLES`.
- Judging is registered. `miss` is high, and `miss_count`/`hit_count` update, on the cycle after the `press` or timeout cycle. The state change lands on the same edge.
- `lamp` goes high on the first WAIT cycle and clears on the edge that leaves WAIT.
- Reset mid-game returns to the reset values on the next edge. In-flight presses are discarded.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no `press`.

## Structure
- Package `judge_pkg`: state enum, `LANES`=4, `LFSR_SEED`=8'hA5, LFSR tap mask, saturation max 8'hFF.
- Sub-module `button_debounce`: synchronizer, debounce counter and edge detect, parameterised by `DEBOUNCE_CYCLES`. Instantiated 5 times.
- Top level holds the FSM, LFSR, gap/window counters and the statistics counters.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `WINDOW_CYCLES`=100, `GAP_CYCLES`=20.
- Start: `btn_start` rises at cycle 10 and bounces 0/1 every 2 cycles until cycle 16 -> exactly one `press`, 4 stable cycles after the last bounce. `start`=1 from the following edge. `lamp`=0 for 20 cycles, then one-hot matching the model LFSR.
- Hit: press the lit lane -> `hit_count`=1, `miss`=0, `lamp`=0 on the next edge, new target after 20 cycles.
- Wrong lane and two-lane press: each -> one `miss` pulse of exactly one cycle, `miss_count` increments by 1, FSM back in ARM.
- Timeout and early press: no press for 100 cycles in WAIT -> `miss` on cycle 101. Lane press during ARM -> `miss` and the gap restarts at 20.
- Fail: `fail`=1 in the same cycle as a correct `press` -> no hit, no `miss`, `start`=0, `lamp`=0, `btn_start` ignored until `reset`.
- Saturation and reset: 260 forced misses -> `miss_count`=255. `reset` mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/judge_pkg.sv
// Shared types and constants for the hit_judge player-input front end.
package judge_pkg;
   localparam int         LANES      = 4;
   localparam logic [7:0] LFSR_SEED  = 8'hA5;
   // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3 of the shift register
   localparam logic [7:0] LFSR_TAPS  = 8'hB8;
   localparam logic [7:0] COUNT_MAX  = 8'hFF;

   typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} judge_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == COUNT_MAX) ? value : value + 8'd1;
   endfunction
endpackage

// File: rtl/button_debounce.sv
// Raw button conditioning: 2-flop synchronizer, stability-count debouncer and
// a registered rising-edge detector producing a single-cycle press.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2, level, level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         press   <= level & ~level_d;
         // Any cycle where synced and accepted levels agree restarts the count
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/hit_judge.sv
// Countdown-game input judge: debounced buttons, LFSR target lamp, hit/miss
// judging FSM and saturating statistics. Stops on the timer's fail level.
module hit_judge
   import judge_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int WINDOW_CYCLES   = 25_000_000,
   parameter int GAP_CYCLES      = 5_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             btn_start,
   input  logic [LANES-1:0] btn_lane,
   input  logic             fail,
   output logic             start,
   output logic             miss,
   output logic [LANES-1:0] lamp,
   output logic [7:0]       hit_count,
   output logic [7:0]       miss_count,
   output judge_state_t     state
);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int WW = $clog2(WINDOW_CYCLES + 1);
   localparam int TW = $clog2(LANES);

   logic             start_press;
   logic [LANES-1:0] lane_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clock (clock),
      .reset (reset),
      .raw   (btn_start),
      .press (start_press)
   );

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clock (clock),
         .reset (reset),
         .raw   (btn_lane[i]),
         .press (lane_press[i])
      );
   end

   judge_state_t     state_q, state_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [WW-1:0]    win_q, win_d;
   logic [TW-1:0]    target_q;
   logic [7:0]       lfsr_q;
   logic [LANES-1:0] target_vec;
   logic             miss_d, hit_d, clear_d, load_d;

   assign target_vec = LANES'(1) << target_q;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      win_d   = win_q;
      miss_d  = 1'b0;
      hit_d   = 1'b0;
      clear_d = 1'b0;
      load_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_press) begin
               state_d = ARM;
               gap_d   = '0;
               clear_d = 1'b1;
            end
         end
         ARM: begin
            if (fail) begin
               state_d = DONE;
            end else if (|lane_press) begin
               miss_d = 1'b1;
               gap_d  = '0;
            end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
               state_d = WAIT;
               win_d   = '0;
               load_d  = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         WAIT: begin
            // fail outranks a same-cycle judgement: no pulse, no count
            if (fail) begin
               state_d = DONE;
            end else if ((|lane_press) || (win_q == WW'(WINDOW_CYCLES - 1))) begin
               state_d = ARM;
               gap_d   = '0;
               if (lane_press == target_vec) hit_d  = 1'b1;
               else                          miss_d = 1'b1;
            end else begin
               win_d = win_q + WW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         gap_q      <= '0;
         win_q      <= '0;
         target_q   <= '0;
         lfsr_q     <= LFSR_SEED;
         miss       <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         gap_q  <= gap_d;
         win_q  <= win_d;
         lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
         miss   <= miss_d;
         if (load_d) target_q <= lfsr_q[TW-1:0];
         if (clear_d) begin
            hit_count  <= '0;
            miss_count <= '0;
         end else begin
            if (hit_d)  hit_count  <= sat_inc(hit_count);
            if (miss_d) miss_count <= sat_inc(miss_count);
         end
      end
   end

   assign start = (state_q == ARM) || (state_q == WAIT);
   assign lamp  = (state_q == WAIT) ? target_vec : '0;
   assign state = state_q;
endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with short debounce, gap and window times.
module tb_hit_judge;
   import judge_pkg::*;

   localparam int DB  = 4;
   localparam int WIN = 100;
   localparam int GAP = 20;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         btn_start = 1'b0;
   logic [3:0]   btn_lane = 4'b0000;
   logic         fail = 1'b0;
   logic         start, miss;
   logic [3:0]   lamp;
   logic [7:0]   hit_count, miss_count;
   judge_state_t state;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_lfsr, m_prev;
   logic [3:0] e, w;
   int         early;
   bit         seen;

   always #5 clock = ~clock;

   // Reference LFSR: x^8+x^6+x^5+x^4 Fibonacci, seeded on reset
   always @(posedge clock) begin
      m_prev <= m_lfsr;
      if (reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   hit_judge #(
      .DEBOUNCE_CYCLES (DB),
      .WINDOW_CYCLES   (WIN),
      .GAP_CYCLES      (GAP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_start  (btn_start),
      .btn_lane   (btn_lane),
      .fail       (fail),
      .start      (start),
      .miss       (miss),
      .lamp       (lamp),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .state      (state)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Drive lanes, return on the judged cycle (8 samples later) with lanes released
   task automatic press_lanes(input logic [3:0] mask);
      btn_lane = mask;
      repeat (8) @(negedge clock);
      btn_lane = 4'b0000;
   endtask

   // Count ARM cycles (n0 already elapsed) until the lamp lights; return the expected lamp
   task automatic arm_to_wait(input int n0, input string tag, output logic [3:0] exp_lamp);
      logic [3:0] one;
      int         n;
      bit         lit;
      one = 4'b0001;
      n   = n0;
      lit = 1'b0;
      for (int k = 0; k < 60 && !lit; k++) begin
         @(negedge clock);
         if (lamp != 4'b0000) lit = 1'b1;
         else                 n++;
      end
      exp_lamp = one << m_prev[1:0];
      check_eq({tag, "_gap_len"}, 32'(n), 32'(GAP));
      check_eq({tag, "_lamp"}, 32'(lamp), 32'(exp_lamp));
   endtask

   task automatic start_game();
      btn_start = 1'b1;
      repeat (8) @(negedge clock);
      check_eq("game_start", 32'(start), 32'd1);
      btn_start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clock);
      check_eq("rst_start", 32'(start), 32'd0);
      check_eq("rst_miss", 32'(miss), 32'd0);
      check_eq("rst_lamp", 32'(lamp), 32'd0);
      check_eq("rst_hits", 32'(hit_count), 32'd0);
      check_eq("rst_misses", 32'(miss_count), 32'd0);
      check_eq("rst_state", 32'(state), 32'(IDLE));
      reset = 1'b0;
      repeat (10) @(negedge clock);

      // Bouncy start press: final edge, then 7 quiet cycles, start on the 8th
      btn_start = 1'b1; @(negedge clock);
      btn_start = 1'b0; @(negedge clock);
      btn_start = 1'b1; repeat (2) @(negedge clock);
      btn_start = 1'b0; repeat (2) @(negedge clock);
      btn_start = 1'b1;
      early = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clock);
         if (start) early++;
      end
      check_eq("start_bounce_quiet", 32'(early), 32'd0);
      @(negedge clock);
      check_eq("start_level", 32'(start), 32'd1);
      check_eq("start_state", 32'(state), 32'(ARM));
      btn_start = 1'b0;
      arm_to_wait(1, "first", e);

      // Correct lane
      press_lanes(e);
      check_eq("hit_count", 32'(hit_count), 32'd1);
      check_eq("hit_no_miss", 32'(miss), 32'd0);
      check_eq("hit_lamp_off", 32'(lamp), 32'd0);
      check_eq("hit_state", 32'(state), 32'(ARM));
      arm_to_wait(1, "after_hit", e);

      // Wrong lane
      w = {e[2:0], e[3]};
      press_lanes(w);
      check_eq("wrong_miss", 32'(miss), 32'd1);
      check_eq("wrong_count", 32'(miss_count), 32'd1);
      check_eq("wrong_hits", 32'(hit_count), 32'd1);
      check_eq("wrong_state", 32'(state), 32'(ARM));
      @(negedge clock);
      check_eq("wrong_pulse_end", 32'(miss), 32'd0);
      arm_to_wait(2, "after_wrong", e);

      // Target plus another lane in the same cycle
      w = {e[2:0], e[3]};
      press_lanes(e | w);
      check_eq("dual_miss", 32'(miss), 32'd1);
      check_eq("dual_count", 32'(miss_count), 32'd2);
      check_eq("dual_hits", 32'(hit_count), 32'd1);
      @(negedge clock);
      check_eq("dual_pulse_end", 32'(miss), 32'd0);
      arm_to_wait(2, "after_dual", e);

      // Timeout: 100 WAIT cycles, miss on the 101st
      repeat (WIN - 1) @(negedge clock);
      check_eq("tmo_before_miss", 32'(miss), 32'd0);
      check_eq("tmo_before_lamp", 32'(lamp), 32'(e));
      @(negedge clock);
      check_eq("tmo_miss", 32'(miss), 32'd1);
      check_eq("tmo_lamp_off", 32'(lamp), 32'd0);
      check_eq("tmo_count", 32'(miss_count), 32'd3);
      check_eq("tmo_state", 32'(state), 32'(ARM));

      // Early press during ARM restarts the gap
      press_lanes(4'b0001);
      check_eq("early_miss", 32'(miss), 32'd1);
      check_eq("early_count", 32'(miss_count), 32'd4);
      check_eq("early_lamp", 32'(lamp), 32'd0);
      arm_to_wait(1, "early_restart", e);

      // fail lands together with a correct press
      btn_lane = e;
      repeat (7) @(negedge clock);
      fail = 1'b1;
      @(negedge clock);
      fail = 1'b0;
      btn_lane = 4'b0000;
      check_eq("fail_hits", 32'(hit_count), 32'd1);
      check_eq("fail_miss", 32'(miss), 32'd0);
      check_eq("fail_count", 32'(miss_count), 32'd4);
      check_eq("fail_start", 32'(start), 32'd0);
      check_eq("fail_lamp", 32'(lamp), 32'd0);
      check_eq("fail_state", 32'(state), 32'(DONE));
      btn_start = 1'b1;
      repeat (10) @(negedge clock);
      btn_start = 1'b0;
      repeat (10) @(negedge clock);
      check_eq("done_start_ignored", 32'(start), 32'd0);
      check_eq("done_state", 32'(state), 32'(DONE));

      // Saturation: 260 early presses, 12 cycles apart, never reaching WAIT
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      start_game();
      for (int i = 0; i < 260; i++) begin
         btn_lane = 4'b0001;
         repeat (6) @(negedge clock);
         btn_lane = 4'b0000;
         repeat (6) @(negedge clock);
         if (i == 249) check_eq("sat_250", 32'(miss_count), 32'd250);
      end
      check_eq("sat_255", 32'(miss_count), 32'd255);
      check_eq("sat_hits", 32'(hit_count), 32'd0);

      // Reset in WAIT with a press in flight
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clock);
         if (lamp != 4'b0000) seen = 1'b1;
      end
      check_eq("sat_reach_wait", 32'(seen), 32'd1);
      btn_lane = 4'b1111;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("mid_rst_start", 32'(start), 32'd0);
      check_eq("mid_rst_lamp", 32'(lamp), 32'd0);
      check_eq("mid_rst_miss", 32'(miss), 32'd0);
      check_eq("mid_rst_misses", 32'(miss_count), 32'd0);
      check_eq("mid_rst_state", 32'(state), 32'(IDLE));
      reset = 1'b0;
      repeat (6) @(negedge clock);
      btn_lane = 4'b0000;
      repeat (12) @(negedge clock);
      check_eq("post_rst_hits", 32'(hit_count), 32'd0);
      check_eq("post_rst_misses", 32'(miss_count), 32'd0);
      check_eq("post_rst_state", 32'(state), 32'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
